// File: rtl/pipe_game_ctrl.sv
// pipe_game_ctrl: round sequencer for the pipe game datapath.
//   Owns the IDLE/PLAY/DYING/OVER round FSM, generates the pipe movement
//   tick (period shrinks with level), keeps score/level and emits a
//   one-cycle clear pulse when a round starts.
// Ports:
//   clk       system clock
//   rstn      synchronous reset, active-high (asserted = 1)
//   key       debounced flap/start button (level)
//   collide   bird overlaps a pipe or boundary (level)
//   pass      one-cycle pulse when a pipe passes the bird
//   start     run enable to the pipe generator (PLAY and DYING)
//   move_en   one-cycle pipe movement tick
//   clr       one-cycle pulse at round start
//   score     current round score (saturating)
//   level     current speed level (saturating)
//   state     0 IDLE, 1 PLAY, 2 DYING, 3 OVER
//   game_over high in OVER
`timescale 1ns/1ps
module pipe_game_ctrl #(
  parameter int unsigned TICK_BASE  = 400000,
  parameter int unsigned TICK_STEP  = 40000,
  parameter int unsigned TICK_MIN   = 120000,
  parameter int unsigned LEVEL_PTS  = 5,
  parameter int unsigned LEVEL_MAX  = 7,
  parameter int unsigned DEATH_HOLD = 50000000,
  parameter int unsigned SCORE_W    = 10
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               key,
  input  logic               collide,
  input  logic               pass,
  output logic               start,
  output logic               move_en,
  output logic               clr,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         level,
  output logic [1:0]         state,
  output logic               game_over
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam logic [31:0] BASE      = 32'(TICK_BASE);
  localparam logic [31:0] STEP      = 32'(TICK_STEP);
  localparam logic [31:0] MIN       = 32'(TICK_MIN);
  // Largest reduction that still stays at or above the floor; computing
  // against this span avoids ever subtracting below zero.
  localparam logic [31:0] SPAN      = (BASE > MIN) ? (BASE - MIN) : 32'd0;
  localparam logic [31:0] PTS_LAST  = (LEVEL_PTS == 0) ? 32'd0 : 32'(LEVEL_PTS - 1);
  localparam logic [31:0] HOLD_LAST = (DEATH_HOLD == 0) ? 32'd0 : 32'(DEATH_HOLD - 1);
  localparam logic [3:0]  LVL_MAX   = 4'(LEVEL_MAX);

  function automatic logic [31:0] period(input logic [3:0] lvl);
    logic [35:0] dec;
    dec = 36'(lvl) * 36'(STEP);
    if (dec >= 36'(SPAN)) period = MIN;
    else                  period = BASE - dec[31:0];
  endfunction

  state_t             st, st_next;
  logic               key_q;
  logic               key_rise;
  logic [31:0]        tick_cnt, tick_next;
  logic [31:0]        hold_cnt, hold_next;
  logic [31:0]        pts_cnt, pts_next;
  logic [SCORE_W-1:0] score_next;
  logic [3:0]         level_next;
  logic               move_next;
  logic               clr_next;

  assign key_rise = key & ~key_q;
  assign state    = st;

  always_comb begin
    st_next    = st;
    tick_next  = tick_cnt;
    hold_next  = hold_cnt;
    pts_next   = pts_cnt;
    score_next = score;
    level_next = level;
    move_next  = 1'b0;
    clr_next   = 1'b0;
    case (st)
      IDLE: begin
        if (key_rise) begin
          st_next    = PLAY;
          clr_next   = 1'b1;
          score_next = '0;
          level_next = '0;
          pts_next   = '0;
          tick_next  = period(4'd0) - 32'd1;
        end
      end
      PLAY: begin
        if (collide) begin
          st_next   = DYING;
          hold_next = '0;
        end else begin
          // Reload uses the level held before this edge, so a level bump
          // only affects the following interval.
          if (tick_cnt == '0) begin
            move_next = 1'b1;
            tick_next = period(level) - 32'd1;
          end else begin
            tick_next = tick_cnt - 32'd1;
          end
          // pts_cnt tracks score modulo LEVEL_PTS without a divider.
          if (pass && (score != '1)) begin
            score_next = score + SCORE_W'(1);
            if (pts_cnt >= PTS_LAST) begin
              pts_next = '0;
              if (level < LVL_MAX) level_next = level + 4'd1;
            end else begin
              pts_next = pts_cnt + 32'd1;
            end
          end
        end
      end
      DYING: begin
        if (hold_cnt >= HOLD_LAST) st_next = OVER;
        else                       hold_next = hold_cnt + 32'd1;
      end
      OVER: begin
        if (key_rise) st_next = IDLE;
      end
      default: st_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      st        <= IDLE;
      key_q     <= 1'b0;
      tick_cnt  <= '0;
      hold_cnt  <= '0;
      pts_cnt   <= '0;
      score     <= '0;
      level     <= '0;
      move_en   <= 1'b0;
      clr       <= 1'b0;
      start     <= 1'b0;
      game_over <= 1'b0;
    end else begin
      st        <= st_next;
      key_q     <= key;
      tick_cnt  <= tick_next;
      hold_cnt  <= hold_next;
      pts_cnt   <= pts_next;
      score     <= score_next;
      level     <= level_next;
      move_en   <= move_next;
      clr       <= clr_next;
      start     <= (st_next == PLAY) || (st_next == DYING);
      game_over <= (st_next == OVER);
    end
  end

endmodule

// File: doc/pipe_game_ctrl.md
Name: pipe_game_ctrl

Overview:
- Top-level game sequencer for the pipe datapath.
- Owns the round state machine (idle, play, dying, over) and drives the `start` and `en` inputs of the pipe generator.
- Produces the pipe movement tick. The tick period shortens as the score rises.
- Counts score from pipe-pass events, freezes motion on collision and emits a one-cycle clear pulse at round start.

Parameters:
- TICK_BASE, 400000: tick period in clk cycles at level 0.
- TICK_STEP, 40000: period reduction per level.
- TICK_MIN, 120000: floor on the tick period.
- LEVEL_PTS, 5: score points per level increment.
- LEVEL_MAX, 7: saturation value of level.
- DEATH_HOLD, 50000000: clk cycles spent in DYING before OVER.
- SCORE_W, 10: score width.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, synchronous, active-high (asserted = 1).
- key  in  1  flap/start button, already synchronised and debounced; level signal.
- collide  in  1  level; bird overlaps a pipe or boundary.
- pass  in  1  one-cycle pulse; a pipe has passed the bird.
- start  out  1  run enable to the pipe generator.
- move_en  out  1  one-cycle movement tick to the pipe generator.
- clr  out  1  one-cycle pulse at round start, used to reinitialise pipes and bird.
- score  out  SCORE_W  current round score.
- level  out  4  current speed level.
- state  out  2  encoding: 0 IDLE, 1 PLAY, 2 DYING, 3 OVER.
- game_over  out  1  high in OVER.

Behaviour:
- Reset, while rstn=1 on a clk edge:
  - state=IDLE; start=0, move_en=0, clr=0, score=0, level=0, game_over=0.
  - Tick counter=0, DEATH_HOLD counter=0, key edge register=0.
  - Reset has priority over every event, including mid-round; all outputs take these values the cycle after the asserting edge.
- Key edge detect: key_rise = key & ~key_q, with key_q registered every cycle. A held key never re-triggers.
- IDLE:
  - start=0, move_en=0.
  - On key_rise: go to PLAY. In that same edge, clr=1 for exactly one cycle, score=0, level=0, and the tick counter is loaded with period(0)-1.
- PLAY:
  - start=1. The tick counter decrements every cycle.
  - When the counter is 0: move_en=1 for one cycle, and the counter reloads with period(level)-1.
  - First move_en occurs period(0) cycles after entering PLAY.
  - period(L) = max(TICK_BASE - L*TICK_STEP, TICK_MIN), computed in at least 32-bit unsigned arithmetic with no underflow (clamp before subtracting).
  - A level change takes effect at the next reload, not mid-count.
  - pass, with no collide in the same cycle:
    - score increments; it saturates at 2^SCORE_W-1 and holds.
    - When the new score is a nonzero multiple of LEVEL_PTS, level increments, saturating at LEVEL_MAX.
  - collide=1: go to DYING. It wins over pass and over a tick in the same cycle: no score change and no move_en that cycle. key is ignored in PLAY.
- DYING:
  - start=1, move_en=0, so pipes hold position.
  - The hold counter counts DEATH_HOLD cycles, then the state goes to OVER.
  - key, collide and pass are ignored. Score is frozen.
- OVER:
  - start=0, game_over=1. Score and level hold their final values.
  - key_rise goes to IDLE, keeping score visible until the next round starts; pass and collide are ignored.
- From IDLE, a key_rise is needed to start, so one press from OVER does not immediately restart.
- A key that is still held when the state enters IDLE does not start a round until it is released and pressed again.
- All outputs are registered; clr and move_en are never high for more than one consecutive cycle.

Test Plan:
- Common parameters: TICK_BASE=10, TICK_STEP=2, TICK_MIN=4, LEVEL_PTS=3, LEVEL_MAX=7, DEATH_HOLD=5.
- Reset, then key pulse:
  - clr is high for 1 cycle and state=1.
  - First move_en arrives 10 cycles later, then every 10 cycles.
  - start=1 throughout PLAY.
- 3 pass pulses, then 3 more:
  - score goes 3 then 6, level goes 1 then 2.
  - The tick spacing after each next reload becomes 8, then 6.
  - With continued passes, level saturates at 7 and the period clamps at 4.
- collide and pass together on the same cycle as a due tick:
  - score is unchanged and no move_en is issued; state goes to 2.
  - After exactly 5 cycles state=3 and game_over=1, while start=1 during DYING and start=0 in OVER.
- key held high continuously from OVER:
  - A single transition to IDLE occurs and the state stays in IDLE.
  - After release and a new press, state=1 with score=0 and level=0.
- rstn asserted mid-PLAY at score=5 with a tick pending:
  - Next cycle state=0, score=0, level=0, start=0, and no move_en or clr.
- pass pulses 1023 times with SCORE_W=10, then 1 more: score holds at 1023.
